// File: rtl/fb_pkg.sv
// Shared definitions for the 1-bit-per-pixel framebuffer write engine.
// Holds the framebuffer geometry, the fill FSM state type, the clipped
// rectangle record and a coordinate clamp helper.
package fb_pkg;

    localparam int CORDW     = 16;
    localparam int FB_WIDTH  = 160;
    localparam int FB_HEIGHT = 120;
    localparam int FB_DATAW  = 1;
    localparam int FB_ADDRW  = $clog2(FB_WIDTH * FB_HEIGHT);

    // Signed coordinate constants used by the clip and walk logic.
    localparam logic signed [CORDW-1:0] COORD_ZERO = '0;
    localparam logic signed [CORDW-1:0] COORD_ONE  = CORDW'(1);
    localparam logic signed [CORDW-1:0] COORD_XLIM = CORDW'(FB_WIDTH);
    localparam logic signed [CORDW-1:0] COORD_YLIM = CORDW'(FB_HEIGHT);
    localparam logic signed [CORDW-1:0] COORD_XMAX = CORDW'(FB_WIDTH - 1);
    localparam logic signed [CORDW-1:0] COORD_YMAX = CORDW'(FB_HEIGHT - 1);

    // Address stride of one framebuffer row.
    localparam logic [FB_ADDRW-1:0] FB_ROW = FB_ADDRW'(FB_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLIP = 2'd1,
        DRAW = 2'd2,
        DONE = 2'd3
    } fb_fill_state_t;

    // Normalised (xa<=xb, ya<=yb) and clamped rectangle; empty means nothing
    // of the original rectangle lies on the framebuffer.
    typedef struct packed {
        logic signed [CORDW-1:0] xa;
        logic signed [CORDW-1:0] ya;
        logic signed [CORDW-1:0] xb;
        logic signed [CORDW-1:0] yb;
        logic                    empty;
    } fb_rect_t;

    // Clamp a signed coordinate into [0, hi].
    function automatic logic signed [CORDW-1:0] clamp_coord(
        input logic signed [CORDW-1:0] v,
        input logic signed [CORDW-1:0] hi
    );
        logic signed [CORDW-1:0] r;
        if (v < COORD_ZERO) begin
            r = COORD_ZERO;
        end else if (v > hi) begin
            r = hi;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/fb_rect_fill_if.sv
// Command and BRAM write-port bundle of the rectangle fill engine.
// master: command issuer / BRAM side (drives start, corners, colr, pause).
// slave : fill engine (drives busy, done, fb_we, fb_addr_write, fb_colr_write).
interface fb_rect_fill_if;
    import fb_pkg::*;

    logic                       start;
    logic signed [CORDW-1:0]    x0;
    logic signed [CORDW-1:0]    y0;
    logic signed [CORDW-1:0]    x1;
    logic signed [CORDW-1:0]    y1;
    logic [FB_DATAW-1:0]        colr;
    logic                       pause;
    logic                       busy;
    logic                       done;
    logic                       fb_we;
    logic [FB_ADDRW-1:0]        fb_addr_write;
    logic [FB_DATAW-1:0]        fb_colr_write;

    modport master (
        output start, x0, y0, x1, y1, colr, pause,
        input  busy, done, fb_we, fb_addr_write, fb_colr_write
    );

    modport slave (
        input  start, x0, y0, x1, y1, colr, pause,
        output busy, done, fb_we, fb_addr_write, fb_colr_write
    );

endinterface

// File: rtl/fb_rect_clip.sv
// Combinational normalise / clamp / empty detect for a rectangle command.
// Ports: x0,y0,x1,y1 (signed corners, inclusive) in; rect (fb_rect_t) out.
module fb_rect_clip
    import fb_pkg::*;
(
    input  logic signed [CORDW-1:0] x0,
    input  logic signed [CORDW-1:0] y0,
    input  logic signed [CORDW-1:0] x1,
    input  logic signed [CORDW-1:0] y1,
    output fb_rect_t                rect
);

    logic signed [CORDW-1:0] xlo;
    logic signed [CORDW-1:0] xhi;
    logic signed [CORDW-1:0] ylo;
    logic signed [CORDW-1:0] yhi;

    // Order the corners, then decide emptiness on the unclamped edges.
    always_comb begin
        xlo = (x0 <= x1) ? x0 : x1;
        xhi = (x0 <= x1) ? x1 : x0;
        ylo = (y0 <= y1) ? y0 : y1;
        yhi = (y0 <= y1) ? y1 : y0;
        rect.empty = (xhi < COORD_ZERO) || (xlo >= COORD_XLIM) ||
                     (yhi < COORD_ZERO) || (ylo >= COORD_YLIM);
        rect.xa = clamp_coord(xlo, COORD_XMAX);
        rect.xb = clamp_coord(xhi, COORD_XMAX);
        rect.ya = clamp_coord(ylo, COORD_YMAX);
        rect.yb = clamp_coord(yhi, COORD_YMAX);
    end

endmodule

// File: rtl/fb_rect_fill.sv
// Filled-rectangle write engine for the 1bpp framebuffer.
// Ports: clk_pix (pixel clock), rst_pix_n (async active-low reset),
//        bus (fb_rect_fill_if.slave): start/corners/colr/pause command in,
//        busy/done status and fb_we/fb_addr_write/fb_colr_write BRAM port out.
// One command at a time: latch, clip for one cycle, then walk the clipped
// rectangle row-major issuing one write per unpaused cycle.
module fb_rect_fill
    import fb_pkg::*;
(
    input  logic           clk_pix,
    input  logic           rst_pix_n,
    fb_rect_fill_if.slave  bus
);

    fb_fill_state_t          state_q, state_d;
    logic signed [CORDW-1:0] x0_q, y0_q, x1_q, y1_q, x0_d, y0_d, x1_d, y1_d;
    logic [FB_DATAW-1:0]     colr_q, colr_d;
    fb_rect_t                rect_q, rect_d;
    logic signed [CORDW-1:0] x_q, y_q, x_d, y_d;
    logic [FB_ADDRW-1:0]     row_base_q, row_base_d;
    logic                    busy_q, busy_d, done_q, done_d, fb_we_q, fb_we_d;
    logic [FB_ADDRW-1:0]     fb_addr_q, fb_addr_d;
    logic [FB_DATAW-1:0]     fb_colr_q, fb_colr_d;

    fb_rect_t                clip_rect;
    logic signed [CORDW-1:0] cur_x, cur_y, cur_xa, cur_xb;
    logic [FB_ADDRW-1:0]     cur_row_base;
    logic                    pending, emit;

    fb_rect_clip u_clip (
        .x0   (x0_q),
        .y0   (y0_q),
        .x1   (x1_q),
        .y1   (y1_q),
        .rect (clip_rect)
    );

    // Walk source: in CLIP the fresh clip result seeds the first pixel so the
    // first write lands right after CLIP; in DRAW the counters are used.
    // The walk is finished once y has stepped past the last row.
    always_comb begin
        if (state_q == CLIP) begin
            cur_x        = clip_rect.xa;
            cur_y        = clip_rect.ya;
            cur_xa       = clip_rect.xa;
            cur_xb       = clip_rect.xb;
            cur_row_base = FB_ADDRW'(clip_rect.ya) * FB_ROW;
            pending      = !clip_rect.empty;
        end else begin
            cur_x        = x_q;
            cur_y        = y_q;
            cur_xa       = rect_q.xa;
            cur_xb       = rect_q.xb;
            cur_row_base = row_base_q;
            pending      = (state_q == DRAW) && !rect_q.empty &&
                           (y_q >= rect_q.ya) && (y_q <= rect_q.yb);
        end
        emit = pending && !bus.pause;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = CLIP;
                else           state_d = IDLE;
            end
            CLIP: begin
                if (clip_rect.empty) state_d = DONE;
                else                 state_d = DRAW;
            end
            DRAW: begin
                if (pending) state_d = DRAW;
                else         state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values; outputs are registered from state_d.
    always_comb begin
        x0_d       = x0_q;
        y0_d       = y0_q;
        x1_d       = x1_q;
        y1_d       = y1_q;
        colr_d     = colr_q;
        x_d        = cur_x;
        y_d        = cur_y;
        row_base_d = cur_row_base;
        fb_we_d    = 1'b0;
        fb_addr_d  = fb_addr_q;
        fb_colr_d  = fb_colr_q;
        if ((state_q == IDLE) && bus.start) begin
            x0_d   = bus.x0;
            y0_d   = bus.y0;
            x1_d   = bus.x1;
            y1_d   = bus.y1;
            colr_d = bus.colr;
        end else begin
            colr_d = colr_q;
        end
        if (state_q == CLIP) rect_d = clip_rect;
        else                 rect_d = rect_q;
        if (emit) begin
            fb_we_d   = 1'b1;
            fb_addr_d = cur_row_base + FB_ADDRW'(cur_x);
            fb_colr_d = colr_q;
            // Row wrap advances the base by one stride: no multiply in the loop.
            if (cur_x == cur_xb) begin
                x_d        = cur_xa;
                y_d        = cur_y + COORD_ONE;
                row_base_d = cur_row_base + FB_ROW;
            end else begin
                x_d        = cur_x + COORD_ONE;
            end
        end else begin
            fb_we_d = 1'b0;
        end
        busy_d = (state_d == CLIP) || (state_d == DRAW);
        done_d = (state_d == DONE);
    end

    // State register.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) state_q <= IDLE;
        else            state_q <= state_d;
    end

    // Command, walk counters and output registers.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            x0_q <= '0; y0_q <= '0; x1_q <= '0; y1_q <= '0;
            colr_q     <= '0;
            rect_q     <= '0;
            x_q        <= '0;
            y_q        <= '0;
            row_base_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fb_we_q    <= 1'b0;
            fb_addr_q  <= '0;
            fb_colr_q  <= '0;
        end else begin
            x0_q <= x0_d; y0_q <= y0_d; x1_q <= x1_d; y1_q <= y1_d;
            colr_q     <= colr_d;
            rect_q     <= rect_d;
            x_q        <= x_d;
            y_q        <= y_d;
            row_base_q <= row_base_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fb_we_q    <= fb_we_d;
            fb_addr_q  <= fb_addr_d;
            fb_colr_q  <= fb_colr_d;
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.fb_we         = fb_we_q;
    assign bus.fb_addr_write = fb_addr_q;
    assign bus.fb_colr_write = fb_colr_q;

endmodule

// File: tb/tb_fb_rect_fill.sv
// Self-checking bench for fb_rect_fill: a rectangle model builds the ordered
// list of expected write addresses; a negedge monitor checks every write.
module tb_fb_rect_fill;
    import fb_pkg::*;

    logic clk_pix = 1'b0;
    logic rst_pix_n;
    fb_rect_fill_if bus();

    fb_rect_fill dut (
        .clk_pix   (clk_pix),
        .rst_pix_n (rst_pix_n),
        .bus       (bus)
    );

    always #5 clk_pix = ~clk_pix;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   exp_q[$];
    logic exp_colr = 1'b0;
    int   we_cnt = 0;
    int   done_cnt = 0;
    int   busy_cnt = 0;
    int   first_we_cyc = -1;
    int   done_cyc = 0;
    int   start_cyc = 0;

    always @(posedge clk_pix) cyc <= cyc + 1;

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Expected writes: normalise, reject if off-screen, clamp, row-major scan.
    function automatic void build_model(input int ax0, input int ay0, input int ax1, input int ay1);
        int xa, xb, ya, yb;
        xa = (ax0 < ax1) ? ax0 : ax1;
        xb = (ax0 < ax1) ? ax1 : ax0;
        ya = (ay0 < ay1) ? ay0 : ay1;
        yb = (ay0 < ay1) ? ay1 : ay0;
        exp_q.delete();
        if (xb < 0 || xa >= FB_WIDTH || yb < 0 || ya >= FB_HEIGHT) return;
        if (xa < 0) xa = 0;
        if (ya < 0) ya = 0;
        if (xb > FB_WIDTH - 1) xb = FB_WIDTH - 1;
        if (yb > FB_HEIGHT - 1) yb = FB_HEIGHT - 1;
        for (int y = ya; y <= yb; y++)
            for (int x = xa; x <= xb; x++)
                exp_q.push_back(y * FB_WIDTH + x);
    endfunction

    // Monitor: every write must be the next expected address with the colour.
    always @(negedge clk_pix) begin
        if (rst_pix_n) begin
            if (bus.fb_we) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write_addr", longint'(bus.fb_addr_write), -1);
                end else begin
                    check("write_addr", longint'(bus.fb_addr_write), exp_q[0]);
                    check("write_colr", longint'(bus.fb_colr_write), longint'(exp_colr));
                    void'(exp_q.pop_front());
                end
                if (first_we_cyc < 0) first_we_cyc = cyc;
                we_cnt++;
            end
            if (bus.done) begin
                check("done_all_written", exp_q.size(), 0);
                done_cnt++;
                done_cyc = cyc;
            end
            if (bus.busy) busy_cnt++;
        end
    end

    task automatic issue(input int ax0, input int ay0, input int ax1, input int ay1, input logic c);
        @(posedge clk_pix); #1;
        bus.start = 1'b1;
        bus.x0 = CORDW'(ax0); bus.y0 = CORDW'(ay0);
        bus.x1 = CORDW'(ax1); bus.y1 = CORDW'(ay1);
        bus.colr = c;
        start_cyc = cyc;
        @(posedge clk_pix); #1;
        // Scramble inputs: the engine must work from the latched command.
        bus.start = 1'b0;
        bus.x0 = -CORDW'(100); bus.y0 = CORDW'(500);
        bus.x1 = CORDW'(77);   bus.y1 = -CORDW'(9);
        bus.colr = ~c;
    endtask

    task automatic run_cmd(input string nm, input int ax0, input int ay0, input int ax1,
                           input int ay1, input logic c, input bit do_pause);
        int  n_exp, d0, stall;
        bit  seen;
        build_model(ax0, ay0, ax1, ay1);
        exp_colr = c;
        n_exp = exp_q.size();
        stall = do_pause ? 3 : 0;
        we_cnt = 0; busy_cnt = 0; first_we_cyc = -1; d0 = done_cnt;
        issue(ax0, ay0, ax1, ay1, c);
        if (do_pause) begin
            seen = 1'b0;
            for (int i = 0; i < 50; i++) begin
                if (we_cnt >= 2) begin seen = 1'b1; break; end
                @(posedge clk_pix); #1;
            end
            check({nm, "_reach_two_writes"}, seen, 1);
            bus.pause = 1'b1;
            bus.start = 1'b1;                    // must be ignored while busy
            bus.x0 = CORDW'(50); bus.y0 = CORDW'(50);
            bus.x1 = CORDW'(51); bus.y1 = CORDW'(51);
            @(posedge clk_pix); #1;
            bus.start = 1'b0;
            @(posedge clk_pix); #1;
            @(posedge clk_pix); #1;
            check({nm, "_pause_holds"}, we_cnt, 3);
            bus.pause = 1'b0;
        end
        seen = 1'b0;
        for (int i = 0; i < 40000; i++) begin
            if (done_cnt > d0) begin seen = 1'b1; break; end
            @(posedge clk_pix); #1;
        end
        check({nm, "_done_seen"}, seen, 1);
        repeat (4) @(posedge clk_pix);
        #1;
        check({nm, "_write_count"}, we_cnt, n_exp);
        check({nm, "_done_latency"}, done_cyc - start_cyc, 2 + n_exp + stall);
        check({nm, "_busy_cycles"}, busy_cnt, 1 + n_exp + stall);
        check({nm, "_single_done"}, done_cnt, d0 + 1);
        if (n_exp > 0) check({nm, "_first_write_latency"}, first_we_cyc - start_cyc, 2);
        else           check({nm, "_no_writes"}, first_we_cyc, -1);
    endtask

    initial begin
        int  d0, w_at_rst;
        bit  seen;
        rst_pix_n = 1'b0;
        bus.start = 1'b0; bus.pause = 1'b0; bus.colr = 1'b0;
        bus.x0 = '0; bus.y0 = '0; bus.x1 = '0; bus.y1 = '0;
        repeat (3) @(posedge clk_pix);
        #1;
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_we", bus.fb_we, 0);
        check("reset_addr", longint'(bus.fb_addr_write), 0);
        check("reset_colr", longint'(bus.fb_colr_write), 0);
        rst_pix_n = 1'b1;

        // Pin the model with hand-computed addresses.
        build_model(10, 5, 12, 6);
        check("model_rect_size", exp_q.size(), 6);
        check("model_rect_first", exp_q[0], 810);
        check("model_rect_row2", exp_q[3], 970);
        check("model_rect_last", exp_q[5], 972);
        build_model(-5, -3, 2, 1);
        check("model_neg_row2", exp_q[3], 160);
        check("model_neg_last", exp_q[exp_q.size() - 1], 162);
        build_model(150, 115, 200, 130);
        check("model_corner_last", exp_q[exp_q.size() - 1], 19199);
        build_model(200, 10, 300, 20);
        check("model_off_size", exp_q.size(), 0);
        exp_q.delete();

        run_cmd("rect",     10,   5,  12,   6, 1'b1, 1'b0);
        run_cmd("reversed", 12,   6,  10,   5, 1'b1, 1'b0);
        run_cmd("neg_clip", -5,  -3,   2,   1, 1'b0, 1'b0);
        run_cmd("corner",  150, 115, 200, 130, 1'b1, 1'b0);
        run_cmd("offscr",  200,  10, 300,  20, 1'b1, 1'b0);
        run_cmd("single",    7,   7,   7,   7, 1'b0, 1'b0);
        run_cmd("paused",    0,   0,   3,   0, 1'b1, 1'b1);

        // Reset in the middle of a full-screen fill.
        build_model(0, 0, 159, 119);
        exp_colr = 1'b1;
        we_cnt = 0; d0 = done_cnt;
        issue(0, 0, 159, 119, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (we_cnt >= 20) begin seen = 1'b1; break; end
            @(posedge clk_pix); #1;
        end
        check("rst_mid_reached", seen, 1);
        #2;
        rst_pix_n = 1'b0;
        #1;
        check("rst_mid_we_low", bus.fb_we, 0);
        check("rst_mid_busy_low", bus.busy, 0);
        check("rst_mid_done_low", bus.done, 0);
        exp_q.delete();
        w_at_rst = we_cnt;
        repeat (3) @(posedge clk_pix);
        #1;
        rst_pix_n = 1'b1;
        repeat (6) @(posedge clk_pix);
        #1;
        check("rst_mid_no_done", done_cnt, d0);
        check("rst_mid_no_writes", we_cnt, w_at_rst);

        run_cmd("after_rst", 10, 5, 12, 6, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
